seq_det_prog: RTL
=================

// Module: seq_det_prog
// PURPOSE
//  Runtime-programmable serial bit-pattern detector, successor to the fixed 1010 detector.
//  Pattern (up to MAX_LEN bits), length and overlap mode are loaded through a config port.
//  Gives a Mealy match strobe, a registered copy, and a saturating match counter.
//  Sits on a serial bit stream qualified by in_valid.
// PARAMETERS
//  MAX_LEN  8        max pattern length in bits (>=2)
//  CNT_W    8        match counter width
//  RST_PAT  8'h0A    pattern after reset (low RST_LEN bits used; default 1010)
//  RST_LEN  4        pattern length after reset
//  RST_OVL  1        overlap mode after reset (1=overlapping)
// PORTS  (LW = $clog2(MAX_LEN+1))
//  clk          in   1        clock, rising edge
//  rst          in   1        async reset, active-low
//  cfg_we       in   1        load cfg_pattern/cfg_len/cfg_overlap this edge
//  cfg_pattern  in   MAX_LEN  pattern; bit[len-1] = first bit received, bit[0] = last
//  cfg_len      in   LW       pattern length; 0 = disabled; >MAX_LEN clamped to MAX_LEN
//  cfg_overlap  in   1        1 = overlapping, 0 = non-overlapping detection
//  in_valid     in   1        x is a valid stream bit this cycle
//  x            in   1        serial data bit
//  cnt_clr      in   1        synchronous clear of match_cnt
//  match        out  1        Mealy: combinational, high in the cycle the last bit arrives
//  match_q      out  1        match registered (1-cycle latency)
//  match_cnt    out  CNT_W    number of matches, saturating
//  cnt_sat      out  1        match_cnt == all-ones
// BEHAVIOUR
//  Reset (rst=0, async): hist=0, fill=0, pattern/len/ovl = RST_*; match_q=0, match_cnt=0, cnt_sat=0.
//  State: hist[MAX_LEN-1:0] = last bits (newest at bit0); fill = valid bits in window, 0..MAX_LEN, sat.
//  match = in_valid & ~cfg_we & len!=0 & (fill+1 >= len) & ({hist,x}[len-1:0] == pattern[len-1:0]).
//  On edge with in_valid & ~cfg_we:
//   - hist <= {hist[MAX_LEN-2:0], x}
//   - fill <= (match & ~ovl) ? 0 : min(fill+1, MAX_LEN)
//   - The non-overlap reset means no bit of a matched window is reused.
//  in_valid=0: hist and fill hold; match=0.
//  cfg_we=1: load the new config and clear hist and fill.
//   - Any in_valid bit in the same cycle is discarded; match=0.
//   - match_cnt is not affected.
//  Equivalent to a KMP-style FSM with len+1 states. With pattern 1010, len 4, ovl 1,
//   cycle behaviour equals the legacy 1010 Mealy detector.
//  match_q <= match every edge.
//  match_cnt: cnt_clr -> 0 (wins over a same-cycle match, which is not counted).
//   Otherwise +1 on match, holding at 2^CNT_W-1.
//  cnt_sat = &match_cnt (combinational from register).
//  Reset mid-stream: partial window is lost. The first match after reset needs len fresh valid bits.
// TESTING
//  1 Reset defaults, in_valid=1, x=1,0,1,0,1,0,0 -> match high on bits 4 and 6; match_q one cycle later; match_cnt=2.
//  2 cfg_overlap=0, pattern 1010 len 4, same stream -> match on bit 4 only; match_cnt=1.
//  3 pattern 3'b111, len 3, x=1 x6: overlap -> matches on bits 3,4,5,6; non-overlap -> bits 3,6.
//  4 Stream 1,0,1,0 with in_valid=0 gaps inserted between bits -> a single match on the 4th valid bit; no match in gap cycles.
//  5 CNT_W=2, 5 matches -> match_cnt 1,2,3,3,3; cnt_sat=1 from the 3rd; cnt_clr with a same-cycle match -> match_cnt=0.
//  6 cfg_len=0 -> no match for any stream; cfg_len=12 (MAX_LEN=8) -> behaves as len 8. rst low after 1,0,1 -> then 0 gives no match.

Source files
------------

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial bit-pattern detector. Pattern, length and overlap mode
// are loaded through a config port. Outputs a Mealy strobe, its registered copy and a saturating count.
module seq_det_prog #(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] RST_PAT = 8'h0A,
  parameter int                 RST_LEN = 4,
  parameter logic               RST_OVL = 1'b1,
  localparam int                LW      = $clog2(MAX_LEN+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               x,
  input  logic               cnt_clr,
  output logic               match,
  output logic               match_q,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  localparam logic [LW-1:0] MAX_L   = LW'(MAX_LEN);
  localparam logic [LW-1:0] RST_L   = (RST_LEN > MAX_LEN) ? LW'(MAX_LEN) : LW'(RST_LEN);
  localparam logic [LW-1:0] ONE_L   = {{(LW-1){1'b0}}, 1'b1};

  logic [MAX_LEN-1:0] hist_r;
  logic [LW-1:0]      fill_r;
  logic [MAX_LEN-1:0] pat_r;
  logic [LW-1:0]      len_r;
  logic               ovl_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               match_q_r;

  logic [MAX_LEN-1:0] win_s;
  logic [MAX_LEN-1:0] mask_s;
  logic [LW:0]        fill_inc_s;
  logic [LW-1:0]      len_ld_s;
  logic               match_s;

  // Window compare: only the low len bits of {hist,x} count, and only once enough bits arrived
  always_comb begin
    win_s      = {hist_r[MAX_LEN-2:0], x};
    mask_s     = {MAX_LEN{1'b0}};
    fill_inc_s = {1'b0, fill_r} + {{LW{1'b0}}, 1'b1};
    match_s    = 1'b0;
    len_ld_s   = cfg_len;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (i < int'(len_r));
    end
    if (cfg_len > MAX_L) begin
      len_ld_s = MAX_L;
    end else begin
      len_ld_s = cfg_len;
    end
    if (in_valid && !cfg_we && (len_r != {LW{1'b0}}) && (fill_inc_s >= {1'b0, len_r}) &&
        (((win_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}})) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
  end

  // History window, fill level and active configuration
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_r <= {MAX_LEN{1'b0}};
      fill_r <= {LW{1'b0}};
      pat_r  <= RST_PAT;
      len_r  <= RST_L;
      ovl_r  <= RST_OVL;
    end else if (cfg_we) begin
      hist_r <= {MAX_LEN{1'b0}};
      fill_r <= {LW{1'b0}};
      pat_r  <= cfg_pattern;
      len_r  <= len_ld_s;
      ovl_r  <= cfg_overlap;
    end else if (in_valid) begin
      hist_r <= win_s;
      // Non-overlapping mode restarts the window so no matched bit is reused
      if (match_s && !ovl_r) begin
        fill_r <= {LW{1'b0}};
      end else if (fill_r == MAX_L) begin
        fill_r <= fill_r;
      end else begin
        fill_r <= fill_r + ONE_L;
      end
    end
  end

  // Saturating match counter; clear wins over a same-cycle match
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (match_s && !(&cnt_r)) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Registered copy of the match strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_q_r <= 1'b0;
    end else begin
      match_q_r <= match_s;
    end
  end

  assign match     = match_s;
  assign match_q   = match_q_r;
  assign match_cnt = cnt_r;
  assign cnt_sat   = &cnt_r;

endmodule
